ysyx_24100012_fetch_buffer: RTL and testbench
=============================================

YSYX_24100012_FETCH_BUFFER -- requirements
Module: ysyx_24100012_fetch_buffer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, instruction width.
- ORIGIN_ADDR, 32'h80000000, reset fetch PC.
- DEPTH, 4, buffer entries, which is also the maximum in-flight requests (power of 2, at least 2).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, reset; synchronous, active-high.
- req_valid, out, 1, memory fetch request.
- req_ready, in, 1, memory accepts the request.
- req_addr, out, ADDR_WIDTH, fetch address.
- rsp_valid, in, 1, in-order response pulse; always accepted.
- rsp_data, in, DATA_WIDTH, fetched word.
- inst_valid, out, 1, instruction available to decode.
- inst_ready, in, 1, decode consumes the instruction.
- inst, out, DATA_WIDTH, head instruction.
- inst_pc, out, ADDR_WIDTH, PC of the head instruction.
- inst_pc_next, out, ADDR_WIDTH, inst_pc+4.
- redirect_valid, in, 1, branch/jump redirect.
- redirect_pc, in, ADDR_WIDTH, redirect target.

Function
REQ-003 fetch_pc SHALL advance by 4 on each req handshake (req_valid & req_ready); req_addr = fetch_pc.
REQ-004 req_valid SHALL be high iff occupancy + inflight + drop_cnt < DEPTH, redirect_valid is low, and the block is not halted.
REQ-005 req_valid and req_addr SHALL stay stable until req_ready, except when redirect_valid or rst is asserted.
REQ-006 Each valid response SHALL be pushed with its PC (PC kept in a parallel PC queue); inst_valid rises in the cycle after rsp_valid (2-cycle minimum from request to inst with a 1-cycle memory).
REQ-007 inst_valid = occupancy != 0; a pop occurs on inst_valid & inst_ready; inst/inst_pc are held stable while inst_ready is low.
REQ-008 A simultaneous push and pop SHALL leave occupancy unchanged; overflow is impossible by the credit rule (REQ-004), and an overflow assertion fires in simulation.
REQ-009 Read and write pointers SHALL wrap modulo DEPTH; occupancy uses log2(DEPTH)+1 bits.
REQ-010 On redirect_valid, in the same clock edge, the block SHALL:
- clear the buffer;
- set fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
- set drop_cnt <= the current inflight count, counting a response arriving in this same cycle as already dropped.
REQ-011 While drop_cnt != 0, each rsp_valid SHALL decrement drop_cnt and be discarded.
REQ-012 A pop coinciding with a redirect SHALL be void: the buffer is flushed regardless.
REQ-013 inflight SHALL increment on a req handshake and decrement on a non-dropped rsp_valid; both in one cycle leaves it unchanged.

Reset
REQ-014 When rst is high at a clock edge, the block SHALL set:
- fetch_pc = ORIGIN_ADDR;
- occupancy, pointers, inflight and drop_cnt = 0;
- req_valid = 0 and inst_valid = 0;
- inst, inst_pc and inst_pc_next = 0.
REQ-015 Reset mid-transaction SHALL abandon outstanding requests; the memory model is reset alongside, and no drop accounting carries across reset.
REQ-016 req_valid MAY assert in the first cycle with rst low.

Configuration
REQ-017 Macro YSYX_24100012_FETCH_HALT_EN:
- Defined: the block adds output io_halt (1 bit, reset 0).
- io_halt sets when an ebreak (32'h00100073) is pushed into the buffer.
- While io_halt is set, no further requests are issued and responses for already in-flight requests are discarded.
- The block stays halted until rst; redirect does not clear io_halt.
- Undefined: the port is absent and ebreak is treated as an ordinary instruction.

Structure
REQ-018 Package ysyx_24100012_pkg SHALL hold WORD_SIZE (4), INST_EBREAK (32'h00100073) and ORIGIN_ADDR default.
REQ-019 Storage SHALL be a sub-module ysyx_24100012_sync_fifo (parametrised width/depth, flush input), instantiated for instruction+PC.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset release, memory 1-cycle, inst_ready=1 -> req_addr 80000000, 80000004, ... one per cycle; first inst_valid 2 cycles after first handshake; inst_pc_next = inst_pc+4.
- inst_ready=0 with memory always ready, DEPTH=4 -> exactly 4 handshakes, then req_valid low; inst_ready=1 -> resumes, PCs contiguous.
- Memory 3-cycle latency, 3 outstanding, redirect_valid with redirect_pc=80000102 -> next req_addr 80000100; the 3 stale responses are dropped; first inst_pc after the redirect is 80000100.
- Redirect in the same cycle as rsp_valid and a pop -> buffer empty next cycle; drop_cnt = inflight-1.
- rst asserted with 2 in flight -> next cycle all outputs at reset values; req_addr 80000000.
- HALT_EN defined, word 00100073 at 80000008 -> io_halt=1 after the push; no req after; 80000008 is delivered to decode.

Source files
------------

// File: rtl/ysyx_24100012_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_24100012_pkg
// Shared constants for the instruction fetch front end.
//   WORD_SIZE           : bytes per instruction word (fetch PC stride)
//   INST_EBREAK         : encoding of ebreak, used by the optional halt logic
//   ORIGIN_ADDR_DEFAULT : default reset fetch PC
// -----------------------------------------------------------------------------
package ysyx_24100012_pkg;

  localparam int unsigned WORD_SIZE           = 4;
  localparam logic [31:0] INST_EBREAK         = 32'h0010_0073;
  localparam logic [31:0] ORIGIN_ADDR_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24100012_sync_fifo.sv
// -----------------------------------------------------------------------------
// ysyx_24100012_sync_fifo
// Single-clock FIFO with synchronous reset and a synchronous flush.
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   flush           : empties the FIFO at the clock edge; wins over push/pop
//   push, push_data : write an entry (caller guarantees space)
//   pop             : remove the head entry (ignored when empty)
//   pop_data        : head entry (valid when !empty)
//   count, empty    : occupancy ($clog2(DEPTH)+1 bits) and empty flag
// -----------------------------------------------------------------------------
module ysyx_24100012_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push;
  assign pop_data = mem[rd_ptr];

  // Storage has no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    !(push && !do_pop && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/ysyx_24100012_fetch_buffer.sv
// -----------------------------------------------------------------------------
// ysyx_24100012_fetch_buffer
// Instruction fetch request generator plus an in-order instruction buffer.
// Requests are credit-limited so that every outstanding request always has a
// buffer slot; a redirect flushes the buffer and discards responses that are
// still in flight for the old path.
//
// Handshakes: a transfer happens on a channel in every cycle where valid and
// ready are both high; a valid source holds its payload stable until that
// transfer (req_* is only withdrawn by redirect or reset). rsp_valid is a
// pulse that is always accepted.
//
// Parameters: ADDR_WIDTH, DATA_WIDTH, ORIGIN_ADDR (reset PC), DEPTH (power of 2).
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr : fetch request to memory
//   rsp_valid/rsp_data           : in-order fetch response
//   inst_valid/inst_ready        : instruction handshake to decode
//   inst, inst_pc, inst_pc_next  : head instruction, its PC, and PC+4
//   redirect_valid/redirect_pc   : branch/jump redirect
//   io_halt                      : only with YSYX_24100012_FETCH_HALT_EN defined;
//                                  sticky halt after an ebreak is buffered
// -----------------------------------------------------------------------------
module ysyx_24100012_fetch_buffer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = ysyx_24100012_pkg::ORIGIN_ADDR_DEFAULT,
  parameter int                    DEPTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] inst_pc_next,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef YSYX_24100012_FETCH_HALT_EN
  ,
  output logic                  io_halt
`endif
);

  import ysyx_24100012_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] expect_pc;   // PC of the next live response
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      drop_cnt;
  logic [CNT_W-1:0]      occupancy;
  logic [CNT_W:0]        credit_used;
  logic                  halted;
  logic                  req_fire;
  logic                  rsp_live;
  logic                  rsp_drop;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [ENT_W-1:0]      head;

  // One extra bit so the three-term sum cannot wrap.
  assign credit_used = {1'b0, occupancy} + {1'b0, inflight} + {1'b0, drop_cnt};

  assign req_valid = !rst && !redirect_valid && !halted &&
                     (credit_used < (CNT_W+1)'(DEPTH));
  assign req_addr  = fetch_pc;
  assign req_fire  = req_valid && req_ready;

  // Responses to pre-redirect requests arrive first (in order); they are the
  // ones counted in drop_cnt.
  assign rsp_drop = rsp_valid && (drop_cnt != '0);
  assign rsp_live = rsp_valid && (drop_cnt == '0);

  // A response in a redirect cycle belongs to the old path and is discarded.
  assign push = rsp_live && !halted && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= ORIGIN_ADDR;
      expect_pc <= ORIGIN_ADDR;
      inflight  <= '0;
      drop_cnt  <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      expect_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      inflight  <= '0;
      // Everything outstanding becomes stale; a response arriving now is
      // already accounted for, whichever counter it came from.
      drop_cnt  <= drop_cnt + inflight - CNT_W'(rsp_valid);
    end else begin
      if (req_fire) fetch_pc  <= fetch_pc + ADDR_WIDTH'(WORD_SIZE);
      if (rsp_live) expect_pc <= expect_pc + ADDR_WIDTH'(WORD_SIZE);
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_live);
      if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  ysyx_24100012_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({rsp_data, expect_pc}),
    .pop       (pop),
    .pop_data  (head),
    .count     (occupancy),
    .empty     (fifo_empty)
  );

  // Outputs read as zero while the buffer is empty, including out of reset.
  assign inst_valid   = !fifo_empty;
  assign inst         = inst_valid ? head[ENT_W-1:ADDR_WIDTH] : '0;
  assign inst_pc      = inst_valid ? head[ADDR_WIDTH-1:0]     : '0;
  assign inst_pc_next = inst_valid ? head[ADDR_WIDTH-1:0] + ADDR_WIDTH'(WORD_SIZE) : '0;

`ifdef YSYX_24100012_FETCH_HALT_EN
  // Sticky until reset; a redirect does not release it.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (push && (rsp_data == DATA_WIDTH'(INST_EBREAK))) begin
      halted <= 1'b1;
    end
  end
  assign io_halt = halted;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24100012_fetch_buffer.sv
module tb_ysyx_24100012_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_next;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
`ifdef YSYX_24100012_FETCH_HALT_EN
  logic        io_halt;
`endif

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  ysyx_24100012_fetch_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_next   (inst_pc_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef YSYX_24100012_FETCH_HALT_EN
    ,
    .io_halt        (io_halt)
`endif
  );

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_ready;
    logic        chk;
    logic        exp_req_valid;
    logic [31:0] exp_req_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_inst_pc;
  } vec_t;

  vec_t vecs[$];

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rv, input logic [31:0] addr,
                            input logic iv, input logic [31:0] ins, input logic [31:0] pc);
    check({tag, ".req_valid"},    {31'd0, req_valid},  {31'd0, rv});
    if (rv) check({tag, ".req_addr"}, req_addr, addr);
    check({tag, ".inst_valid"},   {31'd0, inst_valid}, {31'd0, iv});
    check({tag, ".inst"},         inst,         ins);
    check({tag, ".inst_pc"},      inst_pc,      pc);
    check({tag, ".inst_pc_next"}, inst_pc_next, iv ? pc + 32'd4 : 32'd0);
  endtask

  // driver: inputs change after the falling edge, outputs sampled 1 ns later
  task automatic cyc(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                     input logic ir, input logic dv, input logic [31:0] dpc);
    @(negedge clk);
    rst            = r;
    req_ready      = rr;
    rsp_valid      = rv;
    rsp_data       = rd;
    inst_ready     = ir;
    redirect_valid = dv;
    redirect_pc    = dpc;
    #1;
  endtask

  task automatic reset_dut();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic v(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                   input logic ir, input logic chk, input logic erv, input logic [31:0] eaddr,
                   input logic eiv, input logic [31:0] einst, input logic [31:0] epc);
    vecs.push_back('{r, rr, rv, rd, ir, chk, erv, eaddr, eiv, einst, epc});
  endtask

  initial begin
    // reset, then streaming with a 1-cycle memory and decode always ready
    v(1,0,0,0,0, 0, 0,32'h80000000, 0,0,0);
    v(1,0,0,0,0, 1, 0,32'h80000000, 0,0,0);
    v(0,1,0,0,1, 1, 1,32'h80000000, 0,0,0);
    v(0,1,1,32'hA0,1, 1, 1,32'h80000004, 0,0,0);
    v(0,1,1,32'hA1,1, 1, 1,32'h80000008, 1,32'hA0,32'h80000000);
    v(0,1,1,32'hA2,1, 1, 1,32'h8000000C, 1,32'hA1,32'h80000004);
    v(0,0,1,32'hA3,1, 1, 1,32'h80000010, 1,32'hA2,32'h80000008);
    v(0,0,0,0,1,      1, 1,32'h80000010, 1,32'hA3,32'h8000000C);
    v(0,0,0,0,1,      1, 1,32'h80000010, 0,0,0);
    // reset, then decode stalled: exactly DEPTH handshakes, then resume
    v(1,0,0,0,0, 0, 0,32'h80000000, 0,0,0);
    v(1,0,0,0,0, 1, 0,32'h80000000, 0,0,0);
    v(0,1,0,0,0,      1, 1,32'h80000000, 0,0,0);
    v(0,1,1,32'hB0,0, 1, 1,32'h80000004, 0,0,0);
    v(0,1,1,32'hB1,0, 1, 1,32'h80000008, 1,32'hB0,32'h80000000);
    v(0,1,1,32'hB2,0, 1, 1,32'h8000000C, 1,32'hB0,32'h80000000);
    v(0,1,1,32'hB3,0, 1, 0,32'h80000010, 1,32'hB0,32'h80000000);
    v(0,1,0,0,0,      1, 0,32'h80000010, 1,32'hB0,32'h80000000);
    v(0,1,0,0,1,      1, 0,32'h80000010, 1,32'hB0,32'h80000000);
    v(0,1,0,0,1,      1, 1,32'h80000010, 1,32'hB1,32'h80000004);
    v(0,1,1,32'hB4,1, 1, 1,32'h80000014, 1,32'hB2,32'h80000008);
    v(0,0,1,32'hB5,1, 1, 1,32'h80000018, 1,32'hB3,32'h8000000C);
    v(0,0,0,0,1,      1, 1,32'h80000018, 1,32'hB4,32'h80000010);
    v(0,0,0,0,1,      1, 1,32'h80000018, 1,32'hB5,32'h80000014);
    v(0,0,0,0,1,      1, 1,32'h80000018, 0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].req_ready, vecs[i].rsp_valid, vecs[i].rsp_data,
          vecs[i].inst_ready, 1'b0, 32'h0);
      if (vecs[i].chk)
        check_outs($sformatf("vec%0d", i), vecs[i].exp_req_valid, vecs[i].exp_req_addr,
                   vecs[i].exp_inst_valid, vecs[i].exp_inst, vecs[i].exp_inst_pc);
    end

    // redirect with 3 outstanding on a 3-cycle memory; stale responses dropped
    reset_dut();
    cyc(0,1,0,0,1,0,0);  check("redir.addr0", req_addr, 32'h80000000);
    cyc(0,1,0,0,1,0,0);  check("redir.addr1", req_addr, 32'h80000004);
    cyc(0,1,0,0,1,0,0);  check("redir.addr2", req_addr, 32'h80000008);
    cyc(0,1,1,32'hC0,1,1,32'h80000102);
    check("redir.req_valid_low", {31'd0, req_valid}, 32'd0);
    cyc(0,1,1,32'hC1,1,0,0);
    check_outs("redir.c4", 1, 32'h80000100, 0, 0, 0);
    cyc(0,0,1,32'hC2,1,0,0);
    check_outs("redir.c5", 1, 32'h80000104, 0, 0, 0);
    cyc(0,0,0,0,1,0,0);
    check("redir.c6.inst_valid", {31'd0, inst_valid}, 32'd0);
    cyc(0,0,1,32'hC100,0,0,0);
    check("redir.c7.inst_valid", {31'd0, inst_valid}, 32'd0);
    cyc(0,0,0,0,0,0,0);
    check_outs("redir.c8", 1, 32'h80000104, 1, 32'hC100, 32'h80000100);

    // redirect coinciding with a response and a pop
    reset_dut();
    cyc(0,1,0,0,0,0,0);
    cyc(0,1,1,32'hD0,0,0,0);
    cyc(0,1,0,0,0,0,0);
    check_outs("coinc.c2", 1, 32'h80000008, 1, 32'hD0, 32'h80000000);
    cyc(0,0,1,32'hD1,1,1,32'h80000200);
    cyc(0,0,1,32'hD2,1,0,0);
    check_outs("coinc.c4", 1, 32'h80000200, 0, 0, 0);
    cyc(0,1,0,0,1,0,0);
    check_outs("coinc.c5", 1, 32'h80000200, 0, 0, 0);
    cyc(0,0,1,32'hD200,0,0,0);
    check("coinc.c6.inst_valid", {31'd0, inst_valid}, 32'd0);
    cyc(0,0,0,0,0,0,0);
    check_outs("coinc.c7", 1, 32'h80000204, 1, 32'hD200, 32'h80000200);

    // reset with requests in flight and an entry buffered
    reset_dut();
    cyc(0,1,0,0,0,0,0);
    cyc(0,1,1,32'hE0,0,0,0);
    cyc(0,1,0,0,0,0,0);
    check("rstmid.pre.inst_valid", {31'd0, inst_valid}, 32'd1);
    cyc(1,0,0,0,0,0,0);
    cyc(1,0,0,0,0,0,0);
    check_outs("rstmid.in_reset", 0, 32'h0, 0, 0, 0);
    check("rstmid.req_addr", req_addr, 32'h80000000);
    cyc(0,0,0,0,0,0,0);
    check_outs("rstmid.after", 1, 32'h80000000, 0, 0, 0);

    // ebreak at 80000008
    reset_dut();
    cyc(0,1,0,0,1,0,0);
    cyc(0,1,1,32'hF0,1,0,0);
    cyc(0,1,1,32'hF1,1,0,0);
    cyc(0,1,1,32'h00100073,1,0,0);
`ifdef YSYX_24100012_FETCH_HALT_EN
    check("halt.pre.io_halt", {31'd0, io_halt}, 32'd0);
    cyc(0,1,1,32'hF3,1,0,0);
    check_outs("halt.c4", 0, 32'h0, 1, 32'h00100073, 32'h80000008);
    check("halt.c4.io_halt", {31'd0, io_halt}, 32'd1);
    cyc(0,1,0,0,1,0,0);
    check_outs("halt.c5", 0, 32'h0, 0, 0, 0);
    cyc(0,1,0,0,1,1,32'h80000300);
    cyc(0,1,0,0,1,0,0);
    check_outs("halt.c7", 0, 32'h0, 0, 0, 0);
    check("halt.c7.io_halt", {31'd0, io_halt}, 32'd1);
`else
    cyc(0,0,1,32'hF3,1,0,0);
    check_outs("ebreak.c4", 1, 32'h80000010, 1, 32'h00100073, 32'h80000008);
    cyc(0,0,0,0,1,0,0);
    check_outs("ebreak.c5", 1, 32'h80000010, 1, 32'hF3, 32'h8000000C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
